// File: rtl/hw_fw_timer.sv
// rtl/hw_fw_timer.sv - shared interval timer: prescaled ticks, saturating elapsed count, short/long timeouts
module hw_fw_timer #(
  parameter int CLK_PER_TICK = 1000,
  parameter int SHORT_TICKS  = 3,
  parameter int LONG_TICKS   = 15,
  parameter int PRE_W        = 10,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_reset,
  input  logic             pause,
  output logic             tick,
  output logic [CNT_W-1:0] elapsed,
  output logic             short_timeout,
  output logic             long_timeout
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [CNT_W-1:0] SHORT_TH = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG_TH  = CNT_W'(LONG_TICKS);

  if (CLK_PER_TICK < 1 || SHORT_TICKS < 1 || SHORT_TICKS >= LONG_TICKS ||
      LONG_TICKS >= (1 << CNT_W) || (1 << PRE_W) < CLK_PER_TICK) begin : g_bad_params
    $error("hw_fw_timer: illegal parameter set");
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             tick_q, tick_d;

  always_comb begin
    pre_d     = pre_q;
    elapsed_d = elapsed_q;
    tick_d    = 1'b0;
    if (timer_reset) begin
      pre_d     = '0;
      elapsed_d = '0;
    end else if (!pause) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        // Saturate so the timeouts stay asserted until the controller restarts us.
        if (elapsed_q != LONG_TH) begin
          elapsed_d = elapsed_q + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      elapsed_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      elapsed_q <= elapsed_d;
      tick_q    <= tick_d;
    end
  end

  // Timeouts decode the registered count directly so they track elapsed in the same cycle.
  assign tick          = tick_q;
  assign elapsed       = elapsed_q;
  assign short_timeout = (elapsed_q >= SHORT_TH);
  assign long_timeout  = (elapsed_q >= LONG_TH);

endmodule

// File: tb/tb_hw_fw_timer.sv
// tb/tb_hw_fw_timer.sv - randomized and directed bench for hw_fw_timer against a tick-arithmetic model
module tb_hw_fw_timer;
  localparam int CPT = 4;
  localparam int ST  = 2;
  localparam int LT  = 5;
  localparam int CW  = 8;

  logic          clk;
  logic          rst_n;
  logic          timer_reset;
  logic          pause;
  logic          tick;
  logic [CW-1:0] elapsed;
  logic          short_timeout;
  logic          long_timeout;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  // Model: count of unpaused, unrestarted cycles since the last restart.
  int m_run  = 0;
  int m_tick = 0;

  hw_fw_timer #(
    .CLK_PER_TICK(CPT), .SHORT_TICKS(ST), .LONG_TICKS(LT), .PRE_W(3), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .timer_reset(timer_reset), .pause(pause),
    .tick(tick), .elapsed(elapsed), .short_timeout(short_timeout), .long_timeout(long_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, ecount, got, exp);
    end
  endtask

  function automatic int exp_elapsed();
    int e;
    e = m_run / CPT;
    return (e > LT) ? LT : e;
  endfunction

  task automatic check_all();
    check("tick", int'(tick), m_tick);
    check("elapsed", int'(elapsed), exp_elapsed());
    check("short_timeout", int'(short_timeout), (exp_elapsed() >= ST) ? 1 : 0);
    check("long_timeout", int'(long_timeout), (exp_elapsed() >= LT) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    ecount++;
    if (!rst_n || timer_reset) begin
      m_run  = 0;
      m_tick = 0;
    end else if (pause) begin
      m_tick = 0;
    end else begin
      m_run++;
      m_tick = (m_run % CPT == 0) ? 1 : 0;
    end
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge: asserts reset between edges and releases it one cycle later.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tick", int'(tick), 0);
    check("rst_elapsed", int'(elapsed), 0);
    check("rst_short", int'(short_timeout), 0);
    check("rst_long", int'(long_timeout), 0);
    m_run  = 0;
    m_tick = 0;
    timer_reset = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    timer_reset = 1'b0;
    pause = 1'b0;
    #1;
    check("reset_elapsed", int'(elapsed), 0);
    check("reset_long", int'(long_timeout), 0);
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n  = 1'b1;
    ecount = 0;

    // Free run through saturation.
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 4 || e == 8 || e == 12 || e == 16 || e == 20 || e == 60) check("free_tick", int'(tick), 1);
      if (e == 5) check("free_tick_low", int'(tick), 0);
      if (e == 7) check("free_short_early", int'(short_timeout), 0);
      if (e == 8) check("free_short", int'(short_timeout), 1);
      if (e == 19) check("free_long_early", int'(long_timeout), 0);
      if (e == 20) check("free_long", int'(long_timeout), 1);
      if (e == 60) check("free_sat", int'(elapsed), LT);
    end

    // Async reset while long_timeout is high, then restart at edge 10.
    check("pre_reset_long", int'(long_timeout), 1);
    async_reset();
    for (int e = 1; e <= 32; e++) begin
      timer_reset = (e == 10);
      step();
      if (e == 9) check("rs_short_before", int'(short_timeout), 1);
      if (e == 10) check("rs_cleared", int'(elapsed), 0);
      if (e == 17) check("rs_short_early", int'(short_timeout), 0);
      if (e == 18) check("rs_short", int'(short_timeout), 1);
      if (e == 29) check("rs_long_early", int'(long_timeout), 0);
      if (e == 30) check("rs_long", int'(long_timeout), 1);
    end
    timer_reset = 1'b0;

    // Restart coinciding with a prescaler wrap.
    async_reset();
    for (int e = 1; e <= 12; e++) begin
      timer_reset = (e == 8);
      step();
      if (e == 8) begin
        check("co_tick", int'(tick), 0);
        check("co_elapsed", int'(elapsed), 0);
      end
      if (e >= 8) check("co_short", int'(short_timeout), 0);
    end
    timer_reset = 1'b0;

    // Pause over edges 5..10.
    async_reset();
    for (int e = 1; e <= 16; e++) begin
      pause = (e >= 5 && e <= 10);
      step();
      if (e >= 5 && e <= 10) check("pz_tick", int'(tick), 0);
      if (e == 13) check("pz_short_early", int'(short_timeout), 0);
      if (e == 14) check("pz_short", int'(short_timeout), 1);
    end
    pause = 1'b0;

    // Restart during a pause clears the counter.
    async_reset();
    for (int e = 1; e <= 12; e++) begin
      pause = (e >= 5 && e <= 10);
      timer_reset = (e == 7);
      step();
      if (e == 10) check("pzr_elapsed", int'(elapsed), 0);
    end
    pause = 1'b0;
    timer_reset = 1'b0;

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      timer_reset = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 4) == 0);
      step();
      if (long_timeout && !short_timeout) check("long_implies_short", 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d got=running expected=finished", ecount);
    $fatal(1, "bench timeout");
  end
endmodule
